fwd_scoreboard: RTL and testbench
=================================

// Module: fwd_scoreboard
// PURPOSE
// Parametrised forwarding/hazard unit for the pipelined RISC-V core. It tracks the
// destination registers of in-flight instructions in a shift-register scoreboard.
// For each source operand of the instruction in ID it selects the forwarding stage
// and raises a load-use / early-use stall. Sits between the decoder and the
// ID/EX operand muxes; replaces fixed EX/MEM/WB compare logic.
// PARAMETERS
// NUM_SRC    2  source operands checked per ID instruction
// REG_AW     5  register address width; address 0 is never forwarded
// FWD_DEPTH  3  scoreboard positions after ID (1=EX, 2=MEM, 3=WB)
// ALU_LAT    1  position at which an ALU/JAL result becomes forwardable
// LOAD_LAT   2  position at which load data becomes forwardable
// CNT_W      16 width of the stall performance counter
// SELW = clog2(FWD_DEPTH+1), a localparam
// PORTS
// clk          in   1               clock, rising edge
// rst          in   1               asynchronous, active-high reset
// id_valid     in   1               ID holds a real instruction
// id_rs        in   NUM_SRC*REG_AW  source register addresses, src s at [s*REG_AW+:REG_AW]
// id_rs_used   in   NUM_SRC         source s is actually read
// id_early     in   NUM_SRC         source s is consumed in ID (branch/jalr compare)
// id_rd        in   REG_AW          destination register
// id_regwrite  in   1               instruction writes rd
// id_is_load   in   1               result comes from memory (uses LOAD_LAT)
// pipe_stall   in   1               global freeze (e.g. D-cache miss); scoreboard holds
// flush        in   1               ID instruction is killed (redirect); a bubble is inserted
// fwd_sel      out  NUM_SRC*SELW    0 = register file, k = forward from position k at time of use
// hazard_stall out  1               hold IF/ID and insert a bubble into EX
// sb_busy      out  FWD_DEPTH       per-position valid&&regwrite flags (debug)
// stall_cnt    out  CNT_W           saturating count of hazard_stall cycles
// BEHAVIOUR
// - Entry p = {valid, regwrite, rd, lat}, p=1..FWD_DEPTH; lat = id_is_load ? LOAD_LAT : ALU_LAT.
// - Reset (async): all entries invalid. stall_cnt=0. Outputs therefore fwd_sel=0 and hazard_stall=0.
// - Match for source s: smallest p such that valid && regwrite && rd!=0 && rd==rs_s && id_rs_used[s].
//   The youngest producer wins, and an older one is never selected.
// - Use position u = p + (id_early[s] ? 0 : 1). If u > FWD_DEPTH, then fwd_sel=0 (write-through RF).
//   Otherwise fwd_sel=u.
// - Source s hazard: a match exists && u <= FWD_DEPTH && u < lat+1.
//   hazard_stall = id_valid && !flush && OR over s of the source hazards.
// - fwd_sel/hazard_stall are combinational from the entries and ID inputs. The outputs
//   use the same cycle as the ID decode.
// - Advance when !pipe_stall: entry[p+1] <= entry[p], and the oldest entry is dropped.
//   entry[1] <= {id_valid && !flush && !hazard_stall, id_regwrite, id_rd, lat}.
// - pipe_stall=1: all entries hold. hazard_stall is still computed. pipe_stall has priority
//   over flush and over the bubble insert.
// - flush && hazard_stall same cycle: the flush wins; hazard_stall is forced 0 and a bubble is inserted.
// - stall_cnt increments on every cycle with hazard_stall && !pipe_stall. It saturates at all-ones.
// - A stalled consumer re-evaluates each cycle. With ALU_LAT=1 and LOAD_LAT=2, load-use costs
//   exactly 1 stall, and a branch immediately after a load costs 2.
// - rd=x0 is never recorded as a producer, so it never forwards or stalls.
// STRUCTURE
// - Shared header fwd_defs.vh: position encodings (FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3)
//   and the entry field widths.
// - Sub-module fwd_src_match: per-source priority matcher producing {hit, u, hazard}.
//   It is instantiated NUM_SRC times in a generate loop. The scoreboard registers and
//   the counter live in the top.
// TESTING
// 1 add x5 (ALU) then add x6,x5,x7 next cycle -> fwd_sel[0]=2 (MEM), hazard_stall=0
// 2 lw x5 then add x6,x5,x5 -> 1 cycle hazard_stall=1; then fwd_sel[0]=fwd_sel[1]=3; stall_cnt=1
// 3 lw x5 then beq x5,x0 (early) -> hazard_stall for 2 cycles; then fwd_sel[0]=3
// 4 add x5 at p=1 and add x5 at p=2 both live -> fwd_sel selects the p=1 producer (u=2), not p=2
// 5 pipe_stall=1 for 4 cycles during a load-use -> entries frozen; stall_cnt unchanged;
//   the same stall resolves after release
// 6 flush asserted with a load-use pending -> hazard_stall=0 and a bubble enters;
//   async rst mid-run -> sb_busy=0, stall_cnt=0

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
// Shared definitions for the forwarding scoreboard: position encodings and
// field-width helpers used by the top and the per-source matcher.
package fwd_scoreboard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EX  = 2'd1,
      FWD_MEM = 2'd2,
      FWD_WB  = 2'd3
   } fwd_pos_e;

   // Width needed to hold the larger of the two producer latencies.
   function automatic int unsigned lat_width(input int unsigned alu_lat,
                                             input int unsigned load_lat);
      int unsigned max_lat;
      max_lat = (load_lat > alu_lat) ? load_lat : alu_lat;
      return (max_lat < 32'd1) ? 32'd1 : $clog2(max_lat + 32'd1);
   endfunction

   // Position the producer occupies when the consumer actually reads the operand.
   function automatic int unsigned use_position(input int unsigned p, input logic early);
      return early ? p : p + 32'd1;
   endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Priority matcher for one source operand: finds the youngest live producer of
// rs and reports the forwarding position and whether the value is still too young.
module fwd_src_match
   import fwd_scoreboard_pkg::*;
#(
   parameter int REG_AW    = 5,
   parameter int FWD_DEPTH = 3,
   parameter int LAT_W     = 2,
   parameter int SELW      = 2
) (
   input  logic [FWD_DEPTH-1:0]        sb_valid,
   input  logic [FWD_DEPTH-1:0]        sb_regwrite,
   input  logic [FWD_DEPTH*REG_AW-1:0] sb_rd,
   input  logic [FWD_DEPTH*LAT_W-1:0]  sb_lat,
   input  logic [REG_AW-1:0]           rs,
   input  logic                        rs_used,
   input  logic                        early,
   output logic                        hit,
   output logic [SELW-1:0]             use_pos,
   output logic                        hazard
);

   int unsigned pos_s;
   int unsigned lat_s;
   int unsigned use_s;

   // Scan oldest to youngest so the youngest matching producer overrides older ones.
   always_comb begin
      hit   = 1'b0;
      pos_s = 32'd0;
      lat_s = 32'd0;
      for (int p = FWD_DEPTH - 1; p >= 0; p--) begin
         if (rs_used && sb_valid[p] && sb_regwrite[p] &&
             (sb_rd[p*REG_AW +: REG_AW] != {REG_AW{1'b0}}) &&
             (sb_rd[p*REG_AW +: REG_AW] == rs)) begin
            hit   = 1'b1;
            pos_s = 32'(p + 1);
            lat_s = 32'(sb_lat[p*LAT_W +: LAT_W]);
         end else begin
            hit   = hit;
            pos_s = pos_s;
            lat_s = lat_s;
         end
      end
   end

   // A producer that has left the window is already in the register file.
   always_comb begin
      use_s   = use_position(pos_s, early);
      use_pos = SELW'(FWD_RF);
      hazard  = 1'b0;
      if (hit && (use_s <= 32'(FWD_DEPTH))) begin
         use_pos = SELW'(use_s);
         hazard  = (use_s <= lat_s);
      end else begin
         use_pos = SELW'(FWD_RF);
         hazard  = 1'b0;
      end
   end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard unit: shift-register scoreboard of in-flight destinations,
// per-source forwarding selects, load-use/early-use stall and a stall counter.
module fwd_scoreboard
   import fwd_scoreboard_pkg::*;
#(
   parameter int NUM_SRC   = 2,
   parameter int REG_AW    = 5,
   parameter int FWD_DEPTH = 3,
   parameter int ALU_LAT   = 1,
   parameter int LOAD_LAT  = 2,
   parameter int CNT_W     = 16,
   localparam int SELW     = $clog2(FWD_DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      id_valid,
   input  logic [NUM_SRC*REG_AW-1:0] id_rs,
   input  logic [NUM_SRC-1:0]        id_rs_used,
   input  logic [NUM_SRC-1:0]        id_early,
   input  logic [REG_AW-1:0]         id_rd,
   input  logic                      id_regwrite,
   input  logic                      id_is_load,
   input  logic                      pipe_stall,
   input  logic                      flush,
   output logic [NUM_SRC*SELW-1:0]   fwd_sel,
   output logic                      hazard_stall,
   output logic [FWD_DEPTH-1:0]      sb_busy,
   output logic [CNT_W-1:0]          stall_cnt
);

   localparam int LAT_W = int'(lat_width(ALU_LAT, LOAD_LAT));

   // Bit/field index p-1 holds scoreboard position p (1 = EX).
   logic [FWD_DEPTH-1:0]        sb_valid_r;
   logic [FWD_DEPTH-1:0]        sb_regwrite_r;
   logic [FWD_DEPTH*REG_AW-1:0] sb_rd_r;
   logic [FWD_DEPTH*LAT_W-1:0]  sb_lat_r;
   logic [CNT_W-1:0]            stall_cnt_r;

   logic [NUM_SRC-1:0]          src_hit_s;
   logic [NUM_SRC-1:0]          src_hazard_s;
   logic                        entry_valid_s;
   logic [LAT_W-1:0]            entry_lat_s;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      fwd_src_match #(
         .REG_AW    (REG_AW),
         .FWD_DEPTH (FWD_DEPTH),
         .LAT_W     (LAT_W),
         .SELW      (SELW)
      ) u_match (
         .sb_valid    (sb_valid_r),
         .sb_regwrite (sb_regwrite_r),
         .sb_rd       (sb_rd_r),
         .sb_lat      (sb_lat_r),
         .rs          (id_rs[s*REG_AW +: REG_AW]),
         .rs_used     (id_rs_used[s]),
         .early       (id_early[s]),
         .hit         (src_hit_s[s]),
         .use_pos     (fwd_sel[s*SELW +: SELW]),
         .hazard      (src_hazard_s[s])
      );
   end

   // Stall decision; a flushed ID slot never stalls and enters as a bubble.
   always_comb begin
      hazard_stall  = 1'b0;
      entry_valid_s = 1'b0;
      entry_lat_s   = id_is_load ? LAT_W'(LOAD_LAT) : LAT_W'(ALU_LAT);
      if (id_valid && !flush) begin
         hazard_stall  = |(src_hit_s & src_hazard_s);
         entry_valid_s = !hazard_stall;
      end else begin
         hazard_stall  = 1'b0;
         entry_valid_s = 1'b0;
      end
   end

   // Scoreboard shift: advances one position per unfrozen cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb_valid_r    <= {FWD_DEPTH{1'b0}};
         sb_regwrite_r <= {FWD_DEPTH{1'b0}};
         sb_rd_r       <= {(FWD_DEPTH*REG_AW){1'b0}};
         sb_lat_r      <= {(FWD_DEPTH*LAT_W){1'b0}};
      end else if (!pipe_stall) begin
         for (int p = FWD_DEPTH - 1; p > 0; p--) begin
            sb_valid_r[p]                <= sb_valid_r[p-1];
            sb_regwrite_r[p]             <= sb_regwrite_r[p-1];
            sb_rd_r[p*REG_AW +: REG_AW]  <= sb_rd_r[(p-1)*REG_AW +: REG_AW];
            sb_lat_r[p*LAT_W +: LAT_W]   <= sb_lat_r[(p-1)*LAT_W +: LAT_W];
         end
         sb_valid_r[0]         <= entry_valid_s;
         sb_regwrite_r[0]      <= id_regwrite;
         sb_rd_r[REG_AW-1:0]   <= id_rd;
         sb_lat_r[LAT_W-1:0]   <= entry_lat_s;
      end
   end

   // Saturating count of stall cycles that actually cost a pipeline slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (hazard_stall && !pipe_stall && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign sb_busy   = sb_valid_r & sb_regwrite_r;
   assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed pipeline scenarios plus
// randomized traffic compared against an in-flight instruction queue model.
module tb_fwd_scoreboard;

   localparam int NUM_SRC = 2;
   localparam int REG_AW  = 5;
   localparam int DEPTH   = 3;
   localparam int SELW    = 2;
   localparam int CNT_W   = 16;
   localparam int ALU_L   = 1;
   localparam int LOAD_L  = 2;

   logic                      clk;
   logic                      rst;
   logic                      id_valid;
   logic [NUM_SRC*REG_AW-1:0] id_rs;
   logic [NUM_SRC-1:0]        id_rs_used;
   logic [NUM_SRC-1:0]        id_early;
   logic [REG_AW-1:0]         id_rd;
   logic                      id_regwrite;
   logic                      id_is_load;
   logic                      pipe_stall;
   logic                      flush;
   logic [NUM_SRC*SELW-1:0]   fwd_sel;
   logic                      hazard_stall;
   logic [DEPTH-1:0]          sb_busy;
   logic [CNT_W-1:0]          stall_cnt;

   fwd_scoreboard dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rs_used   (id_rs_used),
      .id_early     (id_early),
      .id_rd        (id_rd),
      .id_regwrite  (id_regwrite),
      .id_is_load   (id_is_load),
      .pipe_stall   (pipe_stall),
      .flush        (flush),
      .fwd_sel      (fwd_sel),
      .hazard_stall (hazard_stall),
      .sb_busy      (sb_busy),
      .stall_cnt    (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // In-flight instructions, index 0 = one stage past ID.
   typedef struct packed {
      logic       valid;
      logic       regwrite;
      logic [4:0] rd;
      logic       is_load;
   } inst_t;

   inst_t       flight_q[$];
   int          n_checks;
   int          n_fail;
   int          exp_cnt;
   logic [3:0]  exp_sel;
   logic        exp_haz;

   task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      flight_q.delete();
      for (int i = 0; i < DEPTH; i++) flight_q.push_back('0);
      exp_cnt = 0;
   endtask

   // Youngest producer of rs decides; operand is read one stage later unless early.
   task automatic model_eval();
      logic       any;
      logic [4:0] rs;
      int         hit_at;
      int         use_at;
      int         lat;
      any     = 1'b0;
      exp_sel = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         rs     = id_rs[s*REG_AW +: REG_AW];
         hit_at = 0;
         for (int p = 1; p <= DEPTH; p++) begin
            if (hit_at == 0 && id_rs_used[s] && flight_q[p-1].valid && flight_q[p-1].regwrite &&
                flight_q[p-1].rd != 5'd0 && flight_q[p-1].rd == rs)
               hit_at = p;
         end
         if (hit_at != 0) begin
            use_at = hit_at + (id_early[s] ? 0 : 1);
            if (use_at <= DEPTH) begin
               exp_sel[s*SELW +: SELW] = 2'(use_at);
               lat = flight_q[hit_at-1].is_load ? LOAD_L : ALU_L;
               if (use_at < lat + 1) any = 1'b1;
            end
         end
      end
      exp_haz = id_valid && !flush && any;
   endtask

   function automatic int unsigned model_busy();
      int unsigned b;
      b = 0;
      for (int p = 0; p < DEPTH; p++)
         if (flight_q[p].valid && flight_q[p].regwrite) b |= (32'd1 << p);
      return b;
   endfunction

   task automatic settle();
      @(negedge clk);
      model_eval();
      check_val("fwd_sel", fwd_sel, exp_sel);
      check_val("hazard_stall", hazard_stall, exp_haz);
      check_val("sb_busy", sb_busy, model_busy());
      check_val("stall_cnt", stall_cnt, exp_cnt);
   endtask

   task automatic tick();
      inst_t n;
      @(posedge clk);
      if (!pipe_stall) begin
         n.valid    = id_valid && !flush && !exp_haz;
         n.regwrite = id_regwrite;
         n.rd       = id_rd;
         n.is_load  = id_is_load;
         flight_q.push_front(n);
         void'(flight_q.pop_back());
         if (exp_haz && exp_cnt < 65535) exp_cnt++;
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [1:0] used, input logic [1:0] early, input logic [4:0] rd,
                        input logic rw, input logic ld, input logic ps, input logic fl);
      id_valid    = v;
      id_rs       = {rs1, rs0};
      id_rs_used  = used;
      id_early    = early;
      id_rd       = rd;
      id_regwrite = rw;
      id_is_load  = ld;
      pipe_stall  = ps;
      flush       = fl;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      idle();
      #2;
      check_val("rst_sb_busy", sb_busy, 0);
      check_val("rst_stall_cnt", stall_cnt, 0);
      check_val("rst_fwd_sel", fwd_sel, 0);
      check_val("rst_hazard", hazard_stall, 0);
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      idle();
      model_clear();
      #1;
      apply_reset();

      // 1: ALU producer followed immediately by a consumer
      drive(1'b1, 5'd1, 5'd2, 2'b00, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); settle(); tick();
      drive(1'b1, 5'd5, 5'd7, 2'b11, 2'b00, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); settle();
      check_val("t1_sel0", fwd_sel[1:0], 2);
      check_val("t1_haz", hazard_stall, 0);
      tick();

      // 2: load-use
      apply_reset();
      drive(1'b1, 5'd1, 5'd0, 2'b01, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0); settle(); tick();
      drive(1'b1, 5'd5, 5'd5, 2'b11, 2'b00, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); settle();
      check_val("t2_haz1", hazard_stall, 1);
      tick(); settle();
      check_val("t2_haz2", hazard_stall, 0);
      check_val("t2_sel0", fwd_sel[1:0], 3);
      check_val("t2_sel1", fwd_sel[3:2], 3);
      check_val("t2_cnt", stall_cnt, 1);
      tick();

      // 3: branch right after a load
      apply_reset();
      drive(1'b1, 5'd1, 5'd0, 2'b01, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0); settle(); tick();
      drive(1'b1, 5'd5, 5'd0, 2'b11, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); settle();
      check_val("t3_haz1", hazard_stall, 1);
      tick(); settle();
      check_val("t3_haz2", hazard_stall, 1);
      tick(); settle();
      check_val("t3_haz3", hazard_stall, 0);
      check_val("t3_sel0", fwd_sel[1:0], 3);
      check_val("t3_cnt", stall_cnt, 2);
      tick();

      // 4: two live producers of x5, youngest wins
      apply_reset();
      drive(1'b1, 5'd1, 5'd0, 2'b01, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); settle(); tick();
      drive(1'b1, 5'd2, 5'd0, 2'b01, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); settle(); tick();
      drive(1'b1, 5'd5, 5'd0, 2'b01, 2'b00, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0); settle();
      check_val("t4_sel0", fwd_sel[1:0], 2);
      tick();

      // 5: freeze during a load-use
      apply_reset();
      drive(1'b1, 5'd1, 5'd0, 2'b01, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0); settle(); tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 5'd5, 5'd0, 2'b01, 2'b00, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0); settle();
         check_val("t5_frz_haz", hazard_stall, 1);
         check_val("t5_frz_busy", sb_busy, 1);
         check_val("t5_frz_cnt", stall_cnt, 0);
         tick();
      end
      drive(1'b1, 5'd5, 5'd0, 2'b01, 2'b00, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); settle();
      check_val("t5_rel_haz", hazard_stall, 1);
      tick(); settle();
      check_val("t5_done_haz", hazard_stall, 0);
      check_val("t5_done_sel", fwd_sel[1:0], 3);
      check_val("t5_done_cnt", stall_cnt, 1);
      tick();

      // 6: flush beats a pending load-use
      apply_reset();
      drive(1'b1, 5'd1, 5'd0, 2'b01, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0); settle(); tick();
      drive(1'b1, 5'd5, 5'd0, 2'b01, 2'b00, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1); settle();
      check_val("t6_flush_haz", hazard_stall, 0);
      tick();
      idle(); settle();
      check_val("t6_bubble_busy", sb_busy, 2);
      check_val("t6_cnt", stall_cnt, 0);
      tick();

      // Randomized traffic over a small register window to provoke overlaps
      apply_reset();
      for (int c = 0; c < 600; c++) begin
         drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               2'($urandom), 2'($urandom_range(0, 3) == 0 ? 1 : 0), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0));
         settle();
         tick();
      end

      // Asynchronous reset in the middle of a cycle
      #2;
      apply_reset();
      for (int c = 0; c < 20; c++) begin
         drive(1'b1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'b11, 2'b00,
               5'($urandom_range(0, 7)), 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         settle();
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
